// File: rtl/spi_vec_loader_pkg.sv
// Shared constants and types for the SPI vector loader.
// Holds the command-byte layout, frame sizing and synchroniser depths used by
// the interface, the synchroniser sub-module and the top.
package spi_vec_loader_pkg;

   // Command byte width, address field width and reserved field width
   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned CMD_ADDR_W = 4;
   localparam int unsigned CMD_RSVD_W = 3;

   // Saturating rejected-frame counter width
   localparam int unsigned BAD_CNT_W  = 8;

   // Synchroniser depths (sclk needs one extra stage for edge detection)
   localparam int unsigned SCLK_SYNC_STAGES = 3;
   localparam int unsigned DATA_SYNC_STAGES = 2;

   // Command byte layout, MSB first: {imm, rsvd[2:0], addr[3:0]}
   typedef struct packed {
      logic                  imm;
      logic [CMD_RSVD_W-1:0] rsvd;
      logic [CMD_ADDR_W-1:0] addr;
   } cmd_t;

   // Full frame length: command byte followed by one register's worth of data
   function automatic int unsigned frame_w(input int unsigned reg_w);
      return ADDR_W + reg_w;
   endfunction

endpackage

// File: rtl/spi_vec_loader_if.sv
// Bus bundle for spi_vec_loader.
// master: drives SPI pins and the load strobe, observes the register outputs.
// slave : the loader itself.
//   i_sclk, i_ss_n, i_mosi : asynchronous SPI mode-0 pins
//   load_if_ready          : one-cycle strobe promoting pending shadow data
//   o_regs                 : live registers, register k at [k*REG_W +: REG_W]
//   o_pending              : per-register shadow-not-yet-live flags
//   o_bad_frames           : saturating count of rejected frames
interface spi_vec_loader_if
   import spi_vec_loader_pkg::*;
#(
   parameter int unsigned NUM_REGS = 6,
   parameter int unsigned REG_W    = 24
) ();

   logic                      i_sclk;
   logic                      i_ss_n;
   logic                      i_mosi;
   logic                      load_if_ready;
   logic [NUM_REGS*REG_W-1:0] o_regs;
   logic [NUM_REGS-1:0]       o_pending;
   logic [BAD_CNT_W-1:0]      o_bad_frames;

   modport master (
      output i_sclk, i_ss_n, i_mosi, load_if_ready,
      input  o_regs, o_pending, o_bad_frames
   );

   modport slave (
      input  i_sclk, i_ss_n, i_mosi, load_if_ready,
      output o_regs, o_pending, o_bad_frames
   );

endinterface

// File: rtl/spi_vec_loader_rx_sync.sv
// spi_rx_sync: brings the asynchronous SPI pins into the clk domain.
//   clk, reset_n   : system clock, synchronous active-low reset
//   i_sclk/i_ss_n/i_mosi : raw SPI pins
//   o_sclk_rise_c  : one-cycle pulse on a synchronised sclk rising edge
//   o_ss_n, o_mosi : synchronised select and data
module spi_rx_sync
   import spi_vec_loader_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic i_sclk,
   input  logic i_ss_n,
   input  logic i_mosi,
   output logic o_sclk_rise_c,
   output logic o_ss_n,
   output logic o_mosi
);

   logic [SCLK_SYNC_STAGES-1:0] r_sclk;
   logic [DATA_SYNC_STAGES-1:0] r_ss_n;
   logic [DATA_SYNC_STAGES-1:0] r_mosi;

   // Synchroniser chains; bit 0 is the first stage. Reset to idle bus levels.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sclk <= '0;
         r_ss_n <= '1;
         r_mosi <= '0;
      end else begin
         r_sclk <= {r_sclk[SCLK_SYNC_STAGES-2:0], i_sclk};
         r_ss_n <= {r_ss_n[DATA_SYNC_STAGES-2:0], i_ss_n};
         r_mosi <= {r_mosi[DATA_SYNC_STAGES-2:0], i_mosi};
      end
   end

   // Rising edge: stage 2 high while stage 3 still low; lines up with mosi stage 2
   assign o_sclk_rise_c = r_sclk[1] & ~r_sclk[2];
   assign o_ss_n        = r_ss_n[DATA_SYNC_STAGES-1];
   assign o_mosi        = r_mosi[DATA_SYNC_STAGES-1];

endmodule

// File: rtl/spi_vec_loader.sv
// spi_vec_loader: SPI-written bank of double-buffered vector registers.
// Each frame is a command byte {imm, rsvd, addr} plus REG_W data bits, MSB
// first. imm=0 frames land in a shadow copy and raise a pending flag until
// load_if_ready promotes them; imm=1 frames write the live copy directly.
//   clk, reset_n : system clock, synchronous active-low reset
//   bus          : spi_vec_loader_if.slave (SPI pins, load strobe, outputs)
module spi_vec_loader
   import spi_vec_loader_pkg::*;
#(
   parameter int unsigned               NUM_REGS = 6,
   parameter int unsigned               REG_W    = 24,
   parameter logic [NUM_REGS*REG_W-1:0] INIT     = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   spi_vec_loader_if.slave bus
);

   localparam int unsigned FRAME_W = frame_w(REG_W);
   localparam int unsigned CNT_W   = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

   typedef logic [CMD_ADDR_W:0] addr_ext_t;

   logic                          w_sclk_rise;
   logic                          w_ss_n;
   logic                          w_mosi;
   cmd_t                          w_cmd;
   logic [REG_W-1:0]              w_data;
   logic                          w_cmd_ok;
   logic [NUM_REGS-1:0]           w_hit;

   logic [CNT_W-1:0]              r_cnt;
   logic [FRAME_W-1:0]            r_shift;
   logic [FRAME_W-1:0]            r_frame;
   logic                          r_last;
   logic                          r_commit;
   logic [NUM_REGS-1:0][REG_W-1:0] r_live;
   logic [NUM_REGS-1:0][REG_W-1:0] r_shadow;
   logic [NUM_REGS-1:0]           r_pending;
   logic [BAD_CNT_W-1:0]          r_bad;

   spi_rx_sync u_sync (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_sclk        (bus.i_sclk),
      .i_ss_n        (bus.i_ss_n),
      .i_mosi        (bus.i_mosi),
      .o_sclk_rise_c (w_sclk_rise),
      .o_ss_n        (w_ss_n),
      .o_mosi        (w_mosi)
   );

   // Bit shifter and frame framing. r_last marks the edge the final bit went
   // in; the commit fires on the next edge with the frame held in r_frame so
   // the first bit of a back-to-back frame cannot disturb it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_shift  <= '0;
         r_frame  <= '0;
         r_last   <= 1'b0;
         r_commit <= 1'b0;
      end else begin
         r_last   <= 1'b0;
         r_commit <= r_last;
         if (r_last) begin
            r_frame <= r_shift;
         end
         if (w_ss_n) begin
            r_cnt <= '0;
         end else if (w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_W-2:0], w_mosi};
            if (r_cnt == LAST_BIT) begin
               r_cnt  <= '0;
               r_last <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Command decode of the committed frame
   assign w_cmd    = cmd_t'(r_frame[FRAME_W-1 -: ADDR_W]);
   assign w_data   = r_frame[REG_W-1:0];
   assign w_cmd_ok = (w_cmd.rsvd == '0) &&
                     (addr_ext_t'(w_cmd.addr) < addr_ext_t'(NUM_REGS));

   // One-hot register select for a valid commit
   always_comb begin
      w_hit = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         w_hit[k] = r_commit && w_cmd_ok && (w_cmd.addr == CMD_ADDR_W'(k));
      end
   end

   // Register bank. Load reads pre-commit shadow/pending; a same-cycle commit
   // is applied afterwards, so an immediate write wins over the load and a
   // shadow write leaves its pending bit set.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_live    <= INIT;
         r_shadow  <= INIT;
         r_pending <= '0;
         r_bad     <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (w_hit[k] && w_cmd.imm) begin
               r_live[k]    <= w_data;
               r_pending[k] <= 1'b0;
            end else if (bus.load_if_ready && r_pending[k]) begin
               r_live[k]    <= r_shadow[k];
               r_pending[k] <= 1'b0;
            end
            if (w_hit[k] && !w_cmd.imm) begin
               r_shadow[k]  <= w_data;
               r_pending[k] <= 1'b1;
            end
         end
         if (r_commit && !w_cmd_ok && (r_bad != '1)) begin
            r_bad <= r_bad + BAD_CNT_W'(1);
         end
      end
   end

   assign bus.o_regs       = r_live;
   assign bus.o_pending    = r_pending;
   assign bus.o_bad_frames = r_bad;

endmodule

// File: tb/tb_spi_vec_loader.sv
// Self-checking bench for spi_vec_loader: bit-bangs SPI frames and load
// strobes, tracks expected register state per transaction, and compares the
// DUT outputs against that state on every falling clk edge.
module tb_spi_vec_loader;

   localparam int NR = 6;
   localparam int RW = 24;
   localparam int FW = 8 + RW;
   localparam int IW = NR * RW;
   localparam logic [IW-1:0] INIT_V = IW'(24'h001800) << RW;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   spi_vec_loader_if #(.NUM_REGS(NR), .REG_W(RW)) bus ();

   spi_vec_loader #(.NUM_REGS(NR), .REG_W(RW), .INIT(INIT_V)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   bit sel      = 1'b0;

   // Expected state
   logic [RW-1:0] m_live   [NR];
   logic [RW-1:0] m_shadow [NR];
   logic [NR-1:0] m_pend;
   int            m_bad;
   logic [IW-1:0] exp_v;

   function automatic void chk(input string name, input logic [IW-1:0] got,
                               input logic [IW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction

   function automatic logic [RW-1:0] get_reg(input int k);
      return bus.o_regs[k*RW +: RW];
   endfunction

   function automatic logic [IW-1:0] m_flat();
      logic [IW-1:0] v;
      for (int k = 0; k < NR; k++) v[k*RW +: RW] = m_live[k];
      return v;
   endfunction

   function automatic void m_reset();
      for (int k = 0; k < NR; k++) begin
         m_live[k]   = INIT_V[k*RW +: RW];
         m_shadow[k] = INIT_V[k*RW +: RW];
      end
      m_pend = '0;
      m_bad  = 0;
   endfunction

   function automatic void m_load();
      for (int k = 0; k < NR; k++) begin
         if (m_pend[k]) begin
            m_live[k] = m_shadow[k];
            m_pend[k] = 1'b0;
         end
      end
   endfunction

   function automatic void m_commit(input logic [7:0] cmd, input logic [RW-1:0] data);
      int a;
      int rsvd;
      a    = int'(cmd) % 16;
      rsvd = (int'(cmd) / 16) % 8;
      if (rsvd != 0 || a >= NR) begin
         if (m_bad < 255) m_bad = m_bad + 1;
      end else if (cmd >= 8'h80) begin
         m_live[a] = data;
         m_pend[a] = 1'b0;
      end else begin
         m_shadow[a] = data;
         m_pend[a]   = 1'b1;
      end
   endfunction

   // Every-cycle comparison against expected state
   always @(negedge clk) begin
      if (chk_en) begin
         chk("regs",    bus.o_regs,               m_flat());
         chk("pending", IW'(bus.o_pending),       IW'(m_pend));
         chk("bad",     IW'(bus.o_bad_frames),    IW'(m_bad));
      end
   end

   task automatic spi_bit(input logic b);
      @(negedge clk) bus.i_sclk = 1'b0; bus.i_mosi = b;
      @(negedge clk);
      @(negedge clk) bus.i_sclk = 1'b1;
      @(negedge clk);
   endtask

   task automatic select_spi();
      @(negedge clk) bus.i_ss_n = 1'b0;
      sel = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic deselect_spi();
      @(negedge clk) bus.i_sclk = 1'b0; bus.i_ss_n = 1'b1;
      sel = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Full frame; expected state changes on the 5th clk edge counting the one
   // that first samples the final sclk high. Optional load on that commit edge.
   task automatic send_frame(input logic [7:0] cmd, input logic [RW-1:0] data, input bit ld);
      logic [FW-1:0] f;
      f = {cmd, data};
      for (int i = FW - 1; i > 0; i--) spi_bit(f[i]);
      @(negedge clk) bus.i_sclk = 1'b0; bus.i_mosi = f[0];
      @(negedge clk);
      @(negedge clk) bus.i_sclk = 1'b1;
      repeat (4) @(posedge clk);
      if (ld) @(negedge clk) bus.load_if_ready = 1'b1;
      @(posedge clk);
      #1;
      if (ld) m_load();
      m_commit(cmd, data);
      if (ld) @(negedge clk) bus.load_if_ready = 1'b0;
   endtask

   task automatic send_partial(input logic [FW-1:0] f, input int n);
      for (int i = 0; i < n; i++) spi_bit(f[FW-1-i]);
      deselect_spi();
   endtask

   task automatic strobe_load();
      @(negedge clk) bus.load_if_ready = 1'b1;
      @(posedge clk);
      #1 m_load();
      @(negedge clk) bus.load_if_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; bus.i_ss_n = 1'b1; bus.i_sclk = 1'b0;
      bus.i_mosi = 1'b0; bus.load_if_ready = 1'b0;
      sel = 1'b0;
      @(posedge clk);
      #1 m_reset();
      @(negedge clk) reset_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      bus.i_sclk = 1'b0; bus.i_ss_n = 1'b1; bus.i_mosi = 1'b0; bus.load_if_ready = 1'b0;
      do_reset();
      chk_en = 1'b1;

      // Reset values
      @(negedge clk);
      chk("rst_reg1",    IW'(get_reg(1)),         IW'(24'h001800));
      chk("rst_reg0",    IW'(get_reg(0)),         IW'(24'h000000));
      chk("rst_pending", IW'(bus.o_pending),      IW'(6'b000000));

      // Shadow write then load
      select_spi();
      send_frame(8'h02, 24'h123456, 1'b0);
      @(negedge clk);
      chk("shadow_pending", IW'(bus.o_pending), IW'(6'b000100));
      chk("shadow_not_live", IW'(get_reg(2)),   IW'(24'h000000));
      strobe_load();
      chk("load_reg2",    IW'(get_reg(2)),      IW'(24'h123456));
      chk("load_pending", IW'(bus.o_pending),   IW'(6'b000000));

      // Immediate write, back-to-back without deselect
      send_frame(8'h83, 24'hABCDEF, 1'b0);
      @(negedge clk);
      chk("imm_reg3",     IW'(get_reg(3)),      IW'(24'hABCDEF));
      chk("imm_pending",  IW'(bus.o_pending),   IW'(6'b000000));

      // Bad address and nonzero reserved field
      send_frame(8'h07, 24'h111111, 1'b0);
      send_frame(8'h40, 24'h222222, 1'b0);
      @(negedge clk);
      exp_v = '0;
      exp_v[1*RW +: RW] = 24'h001800;
      exp_v[2*RW +: RW] = 24'h123456;
      exp_v[3*RW +: RW] = 24'hABCDEF;
      chk("bad_count",     IW'(bus.o_bad_frames), IW'(8'd2));
      chk("bad_regs_same", bus.o_regs,            exp_v);

      // Partial frame discarded, then a full frame
      deselect_spi();
      select_spi();
      send_partial({8'h85, 24'hFFFFFF}, 20);
      select_spi();
      send_frame(8'h00, 24'h000001, 1'b0);
      @(negedge clk);
      chk("partial_pending", IW'(bus.o_pending),   IW'(6'b000001));
      chk("partial_reg5",    IW'(get_reg(5)),      IW'(24'h000000));
      chk("partial_bad",     IW'(bus.o_bad_frames), IW'(8'd2));

      // Commit coincident with load
      send_frame(8'h01, 24'hAAAAAA, 1'b0);
      send_frame(8'h01, 24'hBBBBBB, 1'b1);
      @(negedge clk);
      chk("coinc_reg1",    IW'(get_reg(1)),    IW'(24'hAAAAAA));
      chk("coinc_reg0",    IW'(get_reg(0)),    IW'(24'h000001));
      chk("coinc_pending", IW'(bus.o_pending), IW'(6'b000010));
      strobe_load();
      chk("coinc_shadow1", IW'(get_reg(1)),    IW'(24'hBBBBBB));

      // Immediate write wins over a same-cycle load of the same register
      send_frame(8'h04, 24'h111111, 1'b0);
      send_frame(8'h84, 24'h222222, 1'b1);
      @(negedge clk);
      chk("immwin_reg4",    IW'(get_reg(4)),    IW'(24'h222222));
      chk("immwin_pending", IW'(bus.o_pending), IW'(6'b000000));
      deselect_spi();

      // Randomised traffic
      for (int it = 0; it < 40; it++) begin
         int act;
         logic [7:0] cmd;
         act = int'($urandom_range(0, 9));
         if (act < 6) begin
            cmd[3:0] = 4'($urandom_range(0, 7));
            cmd[6:4] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            cmd[7]   = 1'($urandom_range(0, 1));
            if (!sel) select_spi();
            send_frame(cmd, RW'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) deselect_spi();
         end else if (act < 8) begin
            strobe_load();
         end else begin
            if (!sel) select_spi();
            send_partial(FW'($urandom), int'($urandom_range(1, FW - 1)));
         end
      end
      if (sel) deselect_spi();

      // Rejected-frame counter saturation
      select_spi();
      repeat (256) send_frame(8'h0F, RW'($urandom), 1'b0);
      @(negedge clk);
      chk("bad_saturate", IW'(bus.o_bad_frames), IW'(8'd255));

      // Reset in the middle of a frame
      for (int i = 0; i < 12; i++) spi_bit(1'b1);
      do_reset();
      chk("midrst_regs",    bus.o_regs,               INIT_V);
      chk("midrst_pending", IW'(bus.o_pending),       IW'(6'b000000));
      chk("midrst_bad",     IW'(bus.o_bad_frames),    IW'(8'd0));
      select_spi();
      send_frame(8'h84, 24'h5A5A5A, 1'b0);
      @(negedge clk);
      chk("postrst_reg4", IW'(get_reg(4)), IW'(24'h5A5A5A));
      deselect_spi();

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_vec_loader.md
SPI_VEC_LOADER -- requirements
Module: spi_vec_loader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 6, number of vector registers (2..16).
REQ-002 SHALL have parameter REG_W, default 24, width of each register in bits (8..32).
REQ-003 SHALL have parameter INIT, default {NUM_REGS*REG_W{1'b0}}, flattened reset values, register 0 in LSBs.
REQ-004 SHALL have localparam ADDR_W = 8 (command byte) and FRAME_W = 8 + REG_W.
REQ-005 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 i_sclk  input  1  SPI clock, asynchronous, mode 0; sampled on rising edges.
REQ-008 i_ss_n  input  1  SPI select, active-low, asynchronous.
REQ-009 i_mosi  input  1  SPI data, MSB first.
REQ-010 load_if_ready  input  1  one-cycle strobe; pending shadow data may go live.
REQ-011 o_regs  output  NUM_REGS*REG_W  live registers, flattened, register k at [k*REG_W +: REG_W].
REQ-012 o_pending  output  NUM_REGS  per-register flag; shadow holds data not yet live.
REQ-013 o_bad_frames  output  8  saturating count of rejected frames.

Function
REQ-014 SHALL synchronise i_sclk through 3 flops and i_ss_n and i_mosi through 2 flops each; sclk_rise = stage2 high and stage3 low.
REQ-015 SHALL treat SPI as selected while the synchronised i_ss_n is low; while deselected, the bit counter SHALL be held at 0.
REQ-016 Frame format: 8-bit command {imm, rsvd[2:0], addr[3:0]}, then REG_W data bits, MSB first.
REQ-017 SHALL shift one synchronised MOSI bit per sclk_rise while selected; the counter SHALL wrap to 0 after bit FRAME_W-1, so back-to-back frames are accepted without deselecting.
REQ-018 Frame completion (last bit shifted) SHALL be registered as a one-cycle commit on the following clk edge.
REQ-019 On commit with addr < NUM_REGS and imm=0: shadow[addr] SHALL take the data, and o_pending[addr] SHALL be set.
REQ-020 On commit with addr < NUM_REGS and imm=1: live[addr] SHALL take the data directly, and o_pending[addr] SHALL be cleared.
REQ-021 On commit with addr >= NUM_REGS or rsvd != 0: no register change, and o_bad_frames SHALL increment, saturating at 255.
REQ-022 Deselect before the last bit SHALL discard the partial frame with no commit and no count.
REQ-023 On load_if_ready: every register with o_pending set SHALL copy shadow to live, and its pending bit SHALL clear in the same cycle.
REQ-024 Commit and load_if_ready in the same cycle: the load SHALL use pre-commit shadow and pending; the commit SHALL then apply, leaving a new pending bit set (imm=0) or a live overwrite (imm=1, which wins for that address).
REQ-025 Latency: live update on load SHALL appear on o_regs 1 cycle after the strobe; immediate-write latency SHALL be 5 clk cycles from the first clk edge sampling the final i_sclk high.
REQ-026 Load with no pending bits SHALL be a no-op.

Reset
REQ-027 With reset_n low at a clk edge: live = INIT, shadow = INIT, o_pending = 0, o_bad_frames = 0, counter = 0, commit = 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; synchroniser flops SHALL also be reset (sclk and mosi to 0, ss_n to 1).

Structure
REQ-029 Command field positions, ADDR_W and the frame-format constants SHALL live in the shared package/include beside the fixed-point params.
REQ-030 One sub-module, spi_rx_sync (synchronisers plus sclk_rise), SHALL be instantiated; shifting, decode and the register bank SHALL stay in spi_vec_loader.

Verification
REQ-031 Reset with INIT = reg1 0x001800: o_regs[1] = 0x001800, o_pending = 0.
REQ-032 Frame cmd 0x02, data 0x123456, then load_if_ready: o_pending = 0b000100 after commit; o_regs[2] = 0x123456 one cycle after strobe; pending cleared.
REQ-033 Frame cmd 0x83, data 0xABCDEF: o_regs[3] = 0xABCDEF with no strobe; o_pending[3] = 0.
REQ-034 Frames cmd 0x07 and cmd 0x40: o_bad_frames = 2; o_regs unchanged.
REQ-035 Deselect after 20 bits, then a full frame cmd 0x00, data 0x000001: only the full frame commits.
REQ-036 Commit cmd 0x01 (data B) in the same cycle as load_if_ready, with reg1 pending A: live[1] = A; shadow[1] = B; o_pending[1] = 1.
